// File: rtl/regfile_writer.sv
// regfile_writer: write-side front end for the 32-entry register file.
//
// Collects retiring results from the ALU and the load path through
// valid/ready handshakes into two small FIFOs (index 0 = ALU, 1 = mem).
// It pops at most one head per cycle onto the register file write port and
// keeps a pending-write scoreboard for decode hazard checks.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   alu_valid/ready/rd/data     ALU result handshake
//   mem_valid/ready/rd/data     load result handshake
//   issue_valid, issue_rd       destination reserved at issue
//   busy_mask                   bit r set while a write to r is pending
//   select_write, write_input   register file write port (select 0 = idle)

module regfile_writer #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic [ADDR_W-1:0]    select_write,
    output logic [DATA_W-1:0]    write_input
);

    localparam int unsigned NumRegs = 2**ADDR_W;
    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned EntW    = ADDR_W + DATA_W;
    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [1:0]      in_valid;
    logic [1:0]      ready;
    logic [1:0]      full;
    logic [1:0]      empty;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [EntW-1:0] in_ent [2];
    logic [EntW-1:0] head   [2];

    assign in_valid  = {mem_valid, alu_valid};
    assign in_ent[0] = {alu_rd, alu_data};
    assign in_ent[1] = {mem_rd, mem_data};
    assign alu_ready = ready[0];
    assign mem_ready = ready[1];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [EntW-1:0] mem_q [FIFO_DEPTH];
        logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
        logic [PtrW:0]   cnt_q, cnt_d;

        // Pointers wrap naturally because the depth is a power of two.
        always_comb begin
            wr_ptr_d = wr_ptr_q + PtrW'(push[g]);
            rd_ptr_d = rd_ptr_q + PtrW'(pop[g]);
            cnt_d    = cnt_q + (PtrW + 1)'(push[g]) - (PtrW + 1)'(pop[g]);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_q[wr_ptr_q] <= in_ent[g];
            end
        end

        assign full[g]  = (cnt_q == (PtrW + 1)'(FIFO_DEPTH));
        assign empty[g] = (cnt_q == '0);
        // Ready comes from the full flag only (no pop-ahead) and is forced low in reset.
        assign ready[g] = ~full[g] & ~rst;
        assign push[g]  = in_valid[g] & ready[g];
        assign head[g]  = mem_q[rd_ptr_q];
    end

    logic [StarveW-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]  select_q, select_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [NumRegs-1:0] busy_q, busy_d;
    logic [EntW-1:0]    pop_ent;
    logic [ADDR_W-1:0]  pop_rd;
    logic [DATA_W-1:0]  pop_data;

    always_comb begin
        pop      = '0;
        starve_d = starve_q;
        // Mem normally wins; the ALU wins once it has lost STARVE_LIMIT times in a row.
        if (!empty[0] && !empty[1]) begin
            if (starve_q == StarveW'(STARVE_LIMIT)) begin
                pop[0] = 1'b1;
            end else begin
                pop[1] = 1'b1;
            end
        end else if (!empty[0]) begin
            pop[0] = 1'b1;
        end else if (!empty[1]) begin
            pop[1] = 1'b1;
        end

        if (empty[0] || pop[0]) begin
            starve_d = '0;
        end else if (pop[1]) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    assign pop_ent  = pop[0] ? head[0] : head[1];
    assign pop_rd   = pop_ent[EntW-1 -: ADDR_W];
    assign pop_data = pop_ent[DATA_W-1:0];

    always_comb begin
        select_d = '0;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        // A head targeting r0 is consumed without a write.
        if ((|pop) && (pop_rd != '0)) begin
            select_d = pop_rd;
            wdata_d  = pop_data;
        end
        if (|pop) begin
            busy_d[pop_rd] = 1'b0;
        end
        // Set after clear so a same-edge reservation of the retiring register survives.
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            select_q <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
        end else begin
            starve_q <= starve_d;
            select_q <= select_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    assign select_write = select_q;
    assign write_input  = wdata_q;
    assign busy_mask    = busy_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.

module tb_regfile_writer;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIM   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, mem_valid, mem_ready, issue_valid;
    logic [AW-1:0] alu_rd, mem_rd, issue_rd, select_write;
    logic [DW-1:0] alu_data, mem_data, write_input;
    logic [31:0]   busy_mask;

    always #5 clk = ~clk;

    regfile_writer #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy_mask   (busy_mask),
        .select_write(select_write),
        .write_input (write_input)
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } res_t;

    // Reference model state
    res_t          q_alu[$];
    res_t          q_mem[$];
    int            starve;
    logic [31:0]   m_busy;
    logic [AW-1:0] m_sel;
    logic [DW-1:0] m_data;
    bit            alu_taken, mem_taken;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        q_alu.delete();
        q_mem.delete();
        starve    = 0;
        m_busy    = '0;
        m_sel     = '0;
        m_data    = '0;
        alu_taken = 1'b0;
        mem_taken = 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs that were stable before it.
    task automatic model_edge();
        bit          take_alu, take_mem;
        res_t        h;
        logic [31:0] nb;
        alu_taken = 1'b0;
        mem_taken = 1'b0;
        if (rst) return;
        take_alu = 1'b0;
        take_mem = 1'b0;
        if (q_alu.size() > 0 && q_mem.size() > 0) begin
            if (starve == LIM) take_alu = 1'b1;
            else take_mem = 1'b1;
        end else if (q_alu.size() > 0) begin
            take_alu = 1'b1;
        end else if (q_mem.size() > 0) begin
            take_mem = 1'b1;
        end
        if (q_alu.size() == 0 || take_alu) starve = 0;
        else if (take_mem) starve = starve + 1;

        alu_taken = alu_valid && (q_alu.size() < DEPTH);
        mem_taken = mem_valid && (q_mem.size() < DEPTH);

        nb    = m_busy;
        m_sel = '0;
        if (take_alu || take_mem) begin
            h = take_alu ? q_alu.pop_front() : q_mem.pop_front();
            nb[h.rd] = 1'b0;
            if (h.rd != 0) begin
                m_sel  = h.rd;
                m_data = h.data;
            end
        end
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        nb[0]  = 1'b0;
        m_busy = nb;

        if (alu_taken) q_alu.push_back('{rd: alu_rd, data: alu_data});
        if (mem_taken) q_mem.push_back('{rd: mem_rd, data: mem_data});
    endtask

    task automatic check_outputs();
        check_eq("alu_ready", alu_ready, !rst && q_alu.size() < DEPTH);
        check_eq("mem_ready", mem_ready, !rst && q_mem.size() < DEPTH);
        check_eq("select_write", select_write, m_sel);
        if (m_sel != 0) check_eq("write_input", write_input, m_data);
        check_eq("busy_mask", busy_mask, m_busy);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic logic [AW-1:0] free_reg();
        logic [AW-1:0] r;
        for (int i = 0; i < 64; i++) begin
            r = AW'($urandom_range(31, 1));
            if (!m_busy[r]) return r;
        end
        return '0;
    endfunction

    // New offers only once the previous one was taken; a refused offer is held.
    // With split set, ALU uses rd 1..15 and mem uses rd 16..31 so the source is visible.
    task automatic drive(input int pa, input int pm, input int pi, input bit split);
        if (!(alu_valid && !alu_taken)) begin
            alu_valid = ($urandom_range(99) < pa);
            alu_rd    = split ? AW'($urandom_range(15, 1)) : AW'($urandom_range(31, 0));
            alu_data  = $urandom;
        end
        if (!(mem_valid && !mem_taken)) begin
            mem_valid = ($urandom_range(99) < pm);
            mem_rd    = split ? AW'($urandom_range(31, 16)) : AW'($urandom_range(31, 0));
            mem_data  = $urandom;
        end
        issue_valid = ($urandom_range(99) < pi);
        issue_rd    = free_reg();
    endtask

    int pat[6] = '{1, 1, 0, 1, 1, 0};

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b0;
        alu_valid   = 1'b1;
        alu_rd      = 5'd3;
        alu_data    = 32'h1111_1111;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_alu_ready", alu_ready, 1'b0);
        check_eq("rst_mem_ready", mem_ready, 1'b0);
        check_eq("rst_select", select_write, '0);
        check_eq("rst_wdata", write_input, '0);
        check_eq("rst_busy", busy_mask, '0);
        step();
        step();
        @(negedge clk);
        rst       = 1'b0;
        alu_valid = 1'b0;
        #1;
        check_eq("post_rst_alu_ready", alu_ready, 1'b1);
        check_eq("post_rst_mem_ready", mem_ready, 1'b1);
        step();

        // Single ALU write to r7
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        check_eq("issue7_busy", busy_mask[7], 1'b1);
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_rd      = 5'd7;
        alu_data    = 32'hDEAD_BEEF;
        step();
        alu_valid = 1'b0;
        step();
        check_eq("single_sel", select_write, 5'd7);
        check_eq("single_data", write_input, 32'hDEAD_BEEF);
        check_eq("single_busy7", busy_mask[7], 1'b0);
        step();
        check_eq("single_idle", select_write, '0);

        // rd = 0 is consumed without a write
        alu_valid = 1'b1;
        alu_rd    = '0;
        alu_data  = 32'h1234_5678;
        step();
        alu_valid = 1'b0;
        step();
        check_eq("rd0_sel", select_write, '0);
        check_eq("rd0_busy", busy_mask, '0);
        step();
        check_eq("rd0_drained", alu_ready, 1'b1);

        // Reservation of r9 on the edge that retires r9
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'hCAFE_0009;
        step();
        alu_valid   = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        check_eq("coll_sel", select_write, 5'd9);
        check_eq("coll_busy9", busy_mask[9], 1'b1);
        issue_valid = 1'b0;
        step();
        check_eq("coll_busy9_hold", busy_mask[9], 1'b1);

        // Starvation: both sources saturated
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1'b1);
            step();
        end
        drive(100, 100, 0, 1'b1);
        step();
        drive(100, 100, 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq($sformatf("starve_src%0d", k), select_write >= 16, pat[k]);
            drive(100, 100, 0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1'b1);
            step();
        end

        // Randomized traffic at several load levels
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 250; i++) begin
                case (ph)
                    0: drive(30, 30, 20, 1'b0);
                    1: drive(90, 40, 40, 1'b0);
                    2: drive(40, 95, 30, 1'b0);
                    default: drive(100, 100, 50, 1'b0);
                endcase
                step();
            end
        end

        // Reset with buffered entries drops them
        drive(100, 100, 0, 1'b1);
        step();
        drive(100, 100, 0, 1'b1);
        step();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_alu_ready", alu_ready, 1'b0);
        check_eq("mid_rst_mem_ready", mem_ready, 1'b0);
        check_eq("mid_rst_select", select_write, '0);
        check_eq("mid_rst_wdata", write_input, '0);
        check_eq("mid_rst_busy", busy_mask, '0);
        model_reset();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("post_mid_rst_sel%0d", i), select_write, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
